// File: rtl/immed_encoder_if.sv
// immed_encoder_if
//   Request/response bundle for the instruction-word encoder.
//   Request side : in_valid/in_ready handshake plus fmt, opcode, rd, rs1,
//                  rs2, funct3 and the full 32-bit immed.
//   Response side: out_valid/out_ready handshake plus instrn, out_last,
//                  range_err, and the fmt_err pulse.
//   master : the requester that also consumes the encoded words.
//   slave  : the encoder itself.
interface immed_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [31:0] immed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instrn;
  logic        out_last;
  logic        range_err;
  logic        fmt_err;

  modport master (
    output in_valid, fmt, opcode, rd, rs1, rs2, funct3, immed, out_ready,
    input  in_ready, out_valid, instrn, out_last, range_err, fmt_err
  );

  modport slave (
    input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, immed, out_ready,
    output in_ready, out_valid, instrn, out_last, range_err, fmt_err
  );
endinterface

// File: rtl/immed_encoder.sv
// immed_encoder
//   Packs a format code, register/funct fields and a 32-bit immediate into a
//   RISC-V U/I/S/B/J instruction word, or expands a load-immediate (fmt 5)
//   into a LUI beat followed by an ADDI beat. Output is fully registered.
//   Ports:
//     CLK  - clock, rising edge
//     RST  - synchronous active-high reset
//     bus  - immed_encoder_if.slave (request and response handshakes)
module immed_encoder (
  input  logic           CLK,
  input  logic           RST,
  immed_encoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ONE, LI_HI, LI_LO} state_e;

  state_e      state_q, state_d;
  logic [31:0] instrn_q, instrn_d;
  logic [31:0] addi_q, addi_d;
  logic        last_q, last_d;
  logic        rerr_q, rerr_d;
  logic        fmt_err_q, fmt_err_d;
  logic        accept;

  // Single-word encodings; fmt 5 yields the LUI half of a load-immediate.
  // The LUI upper field is rounded up when bit 11 is set because the
  // following ADDI sign-extends its 12-bit immediate.
  function automatic logic [31:0] encode(input logic [2:0]  f,
                                         input logic [6:0]  op,
                                         input logic [4:0]  rd,
                                         input logic [4:0]  rs1,
                                         input logic [4:0]  rs2,
                                         input logic [2:0]  f3,
                                         input logic [31:0] imm);
    logic [19:0] hi;
    hi = imm[31:12] + {19'd0, imm[11]};
    case (f)
      3'd0:    encode = {imm[31:12], rd, op};
      3'd1:    encode = {imm[11:0], rs1, f3, rd, op};
      3'd2:    encode = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      3'd3:    encode = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      3'd4:    encode = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      3'd5:    encode = {hi, rd, 7'b0110111};
      default: encode = '0;
    endcase
  endfunction

  // Flags immediates whose discarded high bits are not a pure sign
  // extension (or, for branch/jump offsets, that are odd).
  function automatic logic range_chk(input logic [2:0] f, input logic [31:0] imm);
    case (f)
      3'd0:       range_chk = (imm[11:0] != 12'd0);
      3'd1, 3'd2: range_chk = !(&imm[31:11] || ~|imm[31:11]);
      3'd3:       range_chk = imm[0] || !(&imm[31:12] || ~|imm[31:12]);
      3'd4:       range_chk = imm[0] || !(&imm[31:20] || ~|imm[31:20]);
      default:    range_chk = 1'b0;
    endcase
  endfunction

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      instrn_q  <= '0;
      addi_q    <= '0;
      last_q    <= 1'b0;
      rerr_q    <= 1'b0;
      fmt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instrn_q  <= instrn_d;
      addi_q    <= addi_d;
      last_q    <= last_d;
      rerr_q    <= rerr_d;
      fmt_err_q <= fmt_err_d;
    end
  end

  // Next-state and holding-register logic
  always_comb begin
    state_d   = state_q;
    instrn_d  = instrn_q;
    addi_d    = addi_q;
    last_d    = last_q;
    rerr_d    = rerr_q;
    fmt_err_d = 1'b0;
    accept    = bus.in_valid && bus.in_ready;

    case (state_q)
      IDLE: ;
      ONE, LI_LO: if (bus.out_ready) state_d = IDLE;
      LI_HI: begin
        if (bus.out_ready) begin
          state_d  = LI_LO;
          instrn_d = addi_q;
          last_d   = 1'b1;
          rerr_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // in_ready is only high when the current word is gone or leaving this
    // cycle, so a new request may simply overwrite the drain decision.
    if (accept) begin
      case (bus.fmt)
        3'd0, 3'd1, 3'd2, 3'd3, 3'd4: begin
          state_d  = ONE;
          instrn_d = encode(bus.fmt, bus.opcode, bus.rd, bus.rs1, bus.rs2,
                            bus.funct3, bus.immed);
          last_d   = 1'b1;
          rerr_d   = range_chk(bus.fmt, bus.immed);
        end
        3'd5: begin
          state_d  = LI_HI;
          instrn_d = encode(bus.fmt, bus.opcode, bus.rd, bus.rs1, bus.rs2,
                            bus.funct3, bus.immed);
          addi_d   = {bus.immed[11:0], bus.rd, 3'b000, bus.rd, 7'b0010011};
          last_d   = 1'b0;
          rerr_d   = 1'b0;
        end
        default: begin
          state_d   = IDLE;
          fmt_err_d = 1'b1;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.out_valid = (state_q != IDLE);
    bus.in_ready  = !RST && ((state_q == IDLE) ||
                             (((state_q == ONE) || (state_q == LI_LO)) && bus.out_ready));
    bus.instrn    = instrn_q;
    bus.out_last  = last_q;
    bus.range_err = rerr_q;
    bus.fmt_err   = fmt_err_q;
  end

endmodule

// File: tb/tb_immed_encoder.sv
// tb_immed_encoder
//   Directed and randomized stimulus for immed_encoder. A reference model
//   computes each expected output beat with plain arithmetic and queues the
//   beats at acceptance; a negedge monitor compares every cycle.
module tb_immed_encoder;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  immed_encoder_if bus();

  immed_encoder dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] w;
    logic        last;
    logic        rerr;
  } beat_t;

  beat_t q[$];
  logic  exp_fe = 1'b0;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: returns the number of beats (0, 1 or 2) a request yields.
  function automatic void model(input logic [2:0] f, input logic [6:0] op,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [31:0] imm,
                                output int n, output beat_t b0, output beat_t b1);
    int          s;
    logic [31:0] hi;
    s  = $signed(imm);
    b0 = '0;
    b1 = '0;
    n  = 1;
    b0.last = 1'b1;
    case (f)
      3'd0: begin
        b0.w    = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
        b0.rerr = (imm % 32'd4096) != 32'd0;
      end
      3'd1: begin
        b0.w    = (imm << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
        b0.rerr = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        b0.w    = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                | (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'(op);
        b0.rerr = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        b0.w    = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'd1) << 7) | 32'(op);
        b0.rerr = ((s % 2) != 0) || (s < -4096) || (s > 4095);
      end
      3'd4: begin
        b0.w    = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                | (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                | (32'(rd) << 7) | 32'(op);
        b0.rerr = ((s % 2) != 0) || (s < -(1 << 20)) || (s >= (1 << 20));
      end
      3'd5: begin
        hi      = (imm + 32'h800) >> 12;
        b0.w    = (hi << 12) | (32'(rd) << 7) | 32'h37;
        b0.last = 1'b0;
        b1.w    = ((imm & 32'hFFF) << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h13;
        b1.last = 1'b1;
        n       = 2;
      end
      default: n = 0;
    endcase
  endfunction

  // Monitor: outputs and handshakes are stable at the falling edge.
  beat_t mb0, mb1;
  int    mn;
  always @(negedge CLK) begin
    if (RST) begin
      q.delete();
      exp_fe = 1'b0;
      chk("in_ready_in_reset", {31'd0, bus.in_ready}, 32'd0);
    end else begin
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
      chk("fmt_err", {31'd0, bus.fmt_err}, {31'd0, exp_fe});
      chk("in_ready", {31'd0, bus.in_ready},
          {31'd0, (q.size() == 0) || ((q.size() == 1) && bus.out_ready)});
      if (bus.out_valid && q.size() != 0) begin
        chk("instrn", bus.instrn, q[0].w);
        chk("out_last", {31'd0, bus.out_last}, {31'd0, q[0].last});
        chk("range_err", {31'd0, bus.range_err}, {31'd0, q[0].rerr});
        if (bus.out_ready) void'(q.pop_front());
      end
      exp_fe = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        model(bus.fmt, bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.funct3, bus.immed,
              mn, mb0, mb1);
        if (mn == 0) exp_fe = 1'b1;
        if (mn >= 1) q.push_back(mb0);
        if (mn == 2) q.push_back(mb1);
      end
    end
  end

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [31:0] imm);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.fmt      = f;
    bus.opcode   = op;
    bus.rd       = rd;
    bus.rs1      = rs1;
    bus.rs2      = rs2;
    bus.funct3   = f3;
    bus.immed    = imm;
    @(negedge CLK);
    while (!bus.in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
  endtask

  beat_t pb0, pb1;
  int    pn;
  int    vcount;

  initial begin
    bus.in_valid  = 1'b0;
    bus.fmt       = '0;
    bus.opcode    = '0;
    bus.rd        = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.funct3    = '0;
    bus.immed     = '0;
    bus.out_ready = 1'b0;

    // Reference model pinned against hand-computed words.
    model(3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 32'hFFFFFFFF, pn, pb0, pb1);
    chk("model_i_word", pb0.w, 32'hFFF30293);
    chk("model_i_rerr", {31'd0, pb0.rerr}, 32'd0);
    model(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFFFFF8, pn, pb0, pb1);
    chk("model_b_word", pb0.w, 32'hFE208CE3);
    model(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'h00001001, pn, pb0, pb1);
    chk("model_b_rerr", {31'd0, pb0.rerr}, 32'd1);
    model(3'd5, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 32'h12345FFF, pn, pb0, pb1);
    chk("model_li_lui", pb0.w, 32'h12346537);
    chk("model_li_addi", pb1.w, 32'hFFF50513);
    model(3'd5, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 32'hFFFFF800, pn, pb0, pb1);
    chk("model_li_wrap_hi", pb0.w >> 12, 32'd0);
    chk("model_li_wrap_lo", pb1.w >> 20, 32'h800);

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_instrn", bus.instrn, 32'd0);
    chk("rst_out_last", {31'd0, bus.out_last}, 32'd0);
    chk("rst_range_err", {31'd0, bus.range_err}, 32'd0);
    chk("rst_fmt_err", {31'd0, bus.fmt_err}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    RST = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge CLK);
    chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge CLK);
    #1;

    // Directed single-word encodings
    send(3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 32'hFFFFFFFF);
    @(negedge CLK);
    chk("dir_i_word", bus.instrn, 32'hFFF30293);
    chk("dir_i_last", {31'd0, bus.out_last}, 32'd1);
    chk("dir_i_rerr", {31'd0, bus.range_err}, 32'd0);
    @(posedge CLK); #1;
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFFFFF8);
    @(negedge CLK);
    chk("dir_b_word", bus.instrn, 32'hFE208CE3);
    chk("dir_b_rerr", {31'd0, bus.range_err}, 32'd0);
    @(posedge CLK); #1;
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'h00001001);
    @(negedge CLK);
    chk("dir_b_rerr_odd", {31'd0, bus.range_err}, 32'd1);
    @(posedge CLK); #1;

    // LI under backpressure on the LUI beat
    bus.out_ready = 1'b0;
    send(3'd5, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 32'h12345FFF);
    repeat (3) begin
      @(negedge CLK);
      chk("bp_lui_hold", bus.instrn, 32'h12346537);
      chk("bp_lui_last", {31'd0, bus.out_last}, 32'd0);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    @(posedge CLK); #1;
    bus.out_ready = 1'b1;
    @(negedge CLK);
    chk("bp_lui_release", bus.instrn, 32'h12346537);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("bp_addi", bus.instrn, 32'hFFF50513);
    chk("bp_addi_last", {31'd0, bus.out_last}, 32'd1);
    @(posedge CLK); #1;

    // Back-to-back single-word requests
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = (i < 4);
      bus.fmt      = 3'd1;
      bus.opcode   = 7'h13;
      bus.rd       = 5'(i + 1);
      bus.rs1      = 5'd2;
      bus.funct3   = 3'd0;
      bus.immed    = 32'(i * 3);
      @(negedge CLK);
      if (bus.out_valid) vcount++;
      @(posedge CLK); #1;
    end
    bus.in_valid = 1'b0;
    chk("b2b_valid_cycles", 32'(vcount), 32'd4);

    // Reserved format
    send(3'd6, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 32'd0);
    @(negedge CLK);
    chk("rsv_fmt_err", {31'd0, bus.fmt_err}, 32'd1);
    chk("rsv_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge CLK);
    chk("rsv_fmt_err_clear", {31'd0, bus.fmt_err}, 32'd0);
    @(posedge CLK); #1;

    // Reset right after the LUI handshake drops the pending ADDI
    send(3'd5, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 32'h12345FFF);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge CLK);
    chk("rst_mid_no_addi", {31'd0, bus.out_valid}, 32'd0);
    @(posedge CLK); #1;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      int sel;
      r   = int'($urandom_range(0, 15));
      sel = int'($urandom_range(0, 3));
      bus.in_valid  = $urandom_range(0, 1) == 1;
      bus.fmt       = (r < 12) ? 3'(r % 6) : 3'(6 + (r & 1));
      bus.opcode    = 7'($urandom);
      bus.rd        = 5'($urandom);
      bus.rs1       = 5'($urandom);
      bus.rs2       = 5'($urandom);
      bus.funct3    = 3'($urandom);
      case (sel)
        0:       bus.immed = $urandom;
        1:       bus.immed = 32'($signed(int'($urandom_range(0, 8191)) - 4096));
        2:       bus.immed = $urandom << 12;
        default: bus.immed = 32'($signed(int'($urandom_range(0, 4194303)) - 2097152)) & 32'hFFFFFFFE;
      endcase
      bus.out_ready = $urandom_range(0, 3) != 0;
      RST           = $urandom_range(0, 499) == 0;
      @(posedge CLK); #1;
    end

    // Drain
    RST           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
